round_sequencer: RTL

ROUND_SEQUENCER -- requirements
Module: round_sequencer

---
 rtl/round_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/round_sequencer.sv
// Round sequencer: runs num_rounds timer intervals (ARM -> WAIT -> GAP) and reports ticks, completion and faults.
// Optional WAIT watchdog enabled by defining ROUND_SEQ_WATCHDOG_EN.
module round_sequencer #(
  parameter int RW        = 4,
  parameter int ARM_MAX   = 4,
  parameter int WD_CYCLES = 1 << 27
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic          abort,
  input  logic [RW-1:0] num_rounds,
  input  logic          clock_done,
  output logic          start_clock,
  output logic [RW-1:0] round_idx,
  output logic          tick,
  output logic          busy,
  output logic          finished,
  output logic          fault
);

  localparam int AW = $clog2(ARM_MAX + 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_MAX - 1);

  if (RW < 1) begin : g_bad_rw
    $error("RW must be at least 1");
  end
  if (ARM_MAX < 1) begin : g_bad_arm
    $error("ARM_MAX must be at least 1");
  end
  if (WD_CYCLES < 1) begin : g_bad_wd
    $error("WD_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  state_t        state, state_n;
  logic [RW-1:0] latched, latched_n;
  logic [RW-1:0] round_idx_n;
  logic [AW-1:0] arm_cnt, arm_cnt_n;
  logic          start_clock_n, tick_n, busy_n, finished_n, fault_n;

`ifdef ROUND_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WD_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WD_CYCLES - 1);
  logic [WW-1:0] wd_cnt, wd_cnt_n;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_n     = state;
    latched_n   = latched;
    round_idx_n = round_idx;
    fault_n     = fault;
    tick_n      = 1'b0;
    finished_n  = 1'b0;
    arm_cnt_n   = '0;
`ifdef ROUND_SEQ_WATCHDOG_EN
    wd_cnt_n    = '0;
`endif

    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_FAULT: begin
          if (go) begin
            fault_n = 1'b0;
            if (num_rounds != '0) begin
              latched_n   = num_rounds;
              round_idx_n = '0;
              state_n     = S_ARM;
            end else begin
              finished_n = 1'b1;
              state_n    = S_IDLE;
            end
          end
        end
        S_ARM: begin
          // The timer needs a cycle to see start_clock before dropping done.
          if (!clock_done) begin
            state_n = S_WAIT;
          end else if (arm_cnt == ARM_LAST) begin
            state_n = S_FAULT;
            fault_n = 1'b1;
          end else begin
            arm_cnt_n = arm_cnt + AW'(1);
          end
        end
        S_WAIT: begin
          if (clock_done) begin
            round_idx_n = round_idx + RW'(1);
            tick_n      = 1'b1;
            state_n     = S_GAP;
          end else begin
`ifdef ROUND_SEQ_WATCHDOG_EN
            if (wd_cnt == WD_LAST) begin
              state_n = S_FAULT;
              fault_n = 1'b1;
            end else begin
              wd_cnt_n = wd_cnt + WW'(1);
            end
`endif
          end
        end
        S_GAP: begin
          if (round_idx == latched) begin
            state_n    = S_DONE;
            finished_n = 1'b1;
          end else begin
            state_n = S_ARM;
          end
        end
        S_DONE: state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    start_clock_n = (state_n == S_ARM) || (state_n == S_WAIT);
    busy_n        = (state_n == S_ARM) || (state_n == S_WAIT) || (state_n == S_GAP);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      latched     <= '0;
      round_idx   <= '0;
      arm_cnt     <= '0;
      start_clock <= 1'b0;
      tick        <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      fault       <= 1'b0;
`ifdef ROUND_SEQ_WATCHDOG_EN
      wd_cnt      <= '0;
`endif
    end else begin
      state       <= state_n;
      latched     <= latched_n;
      round_idx   <= round_idx_n;
      arm_cnt     <= arm_cnt_n;
      start_clock <= start_clock_n;
      tick        <= tick_n;
      busy        <= busy_n;
      finished    <= finished_n;
      fault       <= fault_n;
`ifdef ROUND_SEQ_WATCHDOG_EN
      wd_cnt      <= wd_cnt_n;
`endif
    end
  end

endmodule
